// File: rtl/pchip_seq_pkg.sv
// Shared definitions for the pchip fire/done sequencer: FSM states, default sizes, clog2.
package pchip_seq_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StFire = 2'd1,
        StWait = 2'd2,
        StDone = 2'd3
    } pchip_state_e;

    localparam int unsigned DEF_N_CH = 4;
    localparam int unsigned DEF_TO_W = 16;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pchip_seq_next_ch.sv
// Combinational finder: lowest set bit of mask strictly above idx, or the lowest set bit of the
// whole mask when from_start is high (the "index = -1" search used at accept).
module pchip_seq_next_ch #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic [N_CH-1:0]  mask,
    input  logic [PTR_W-1:0] idx,
    input  logic             from_start,
    output logic [PTR_W-1:0] nxt,
    output logic             vld
);

    // Scan downwards so the lowest qualifying index is the last one written.
    always_comb begin
        nxt = '0;
        vld = 1'b0;
        for (int i = int'(N_CH) - 1; i >= 0; i--) begin
            if (mask[i] && (from_start || (i > int'(idx)))) begin
                nxt = PTR_W'(i);
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pchip_seq.sv
// pchip fire/done sequencer: fans one fire_pchip out to N_CH channels, sequentially or in
// parallel, and returns one done_pchip. Optional per-channel timeout when PCHIP_SEQ_TIMEOUT_EN
// is defined; without it err_ch stays 0 and to_lim is ignored.
module pchip_seq
    import pchip_seq_pkg::*;
#(
    parameter int unsigned N_CH = DEF_N_CH,
    parameter int unsigned TO_W = DEF_TO_W
) (
    input  logic            clk_sys,
    input  logic            rst,
    input  logic            fire_pchip,
    input  logic [N_CH-1:0] ch_en,
    input  logic            mode_par,
    input  logic [TO_W-1:0] to_lim,
    output logic            done_pchip,
    output logic            busy,
    output logic [N_CH-1:0] fire_ch,
    input  logic [N_CH-1:0] done_ch,
    output logic [N_CH-1:0] err_ch,
    output logic            ovr
);

    localparam int unsigned PTR_W = (N_CH > 1) ? clog2(N_CH) : 1;

    pchip_state_e    state_q, state_d;
    logic [N_CH-1:0] mask_q, mask_d;
    logic [N_CH-1:0] pend_q, pend_d;
    logic [N_CH-1:0] fire_q, fire_d;
    logic [N_CH-1:0] err_q, err_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic            mode_q, mode_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic            ovr_q, ovr_d;
    logic            expire;

    logic [N_CH-1:0] pend_nx;
    logic [PTR_W-1:0] nxt_idx;
    logic             nxt_vld;
    logic             in_idle;

    assign in_idle = (state_q == StIdle);

    pchip_seq_next_ch #(
        .N_CH (N_CH),
        .PTR_W(PTR_W)
    ) u_next_ch (
        .mask      (in_idle ? ch_en : mask_q),
        .idx       (ptr_q),
        .from_start(in_idle),
        .nxt       (nxt_idx),
        .vld       (nxt_vld)
    );

`ifdef PCHIP_SEQ_TIMEOUT_EN
    logic [TO_W-1:0] cnt_q, lim_q;

    // Timeout counter: cleared in FIRE, counts WAIT cycles and saturates; limit latched at accept.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            cnt_q <= '0;
            lim_q <= '0;
        end else begin
            if (in_idle && fire_pchip) lim_q <= to_lim;
            if (state_q == StFire) begin
                cnt_q <= '0;
            end else if (state_q == StWait && cnt_q != '1) begin
                cnt_q <= cnt_q + TO_W'(1);
            end
        end
    end

    // The expiry cycle is the lim-th WAIT cycle; a zero limit never expires.
    assign expire = (lim_q != '0) && (cnt_q >= lim_q - TO_W'(1));
`else
    logic unused_to_lim;
    assign unused_to_lim = ^to_lim;
    assign expire        = 1'b0;
`endif

    // Next-state logic; outputs are precomputed from the next state so they come out registered.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        pend_d  = pend_q;
        err_d   = err_q;
        ptr_d   = ptr_q;
        mode_d  = mode_q;
        ovr_d   = ovr_q;
        pend_nx = pend_q & ~done_ch;

        unique case (state_q)
            StIdle: begin
                if (fire_pchip) begin
                    mask_d = ch_en;
                    pend_d = ch_en;
                    mode_d = mode_par;
                    err_d  = '0;
                    ovr_d  = 1'b0;
                    if (ch_en == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StFire;
                        ptr_d   = nxt_idx;
                    end
                end
            end
            StFire: state_d = StWait;
            StWait: begin
                if (!mode_q) begin
                    // A done in the expiry cycle wins over the timeout.
                    if (done_ch[ptr_q] || expire) begin
                        if (!done_ch[ptr_q]) err_d[ptr_q] = 1'b1;
                        if (nxt_vld) begin
                            ptr_d   = nxt_idx;
                            state_d = StFire;
                        end else begin
                            state_d = StDone;
                        end
                    end
                end else begin
                    pend_d = pend_nx;
                    if (pend_nx == '0) begin
                        state_d = StDone;
                    end else if (expire) begin
                        err_d   = err_q | pend_nx;
                        pend_d  = '0;
                        state_d = StDone;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Requests while busy are never queued, only flagged.
        if (!in_idle && fire_pchip) ovr_d = 1'b1;

        fire_d = '0;
        if (state_d == StFire) fire_d = mode_d ? mask_d : (N_CH'(1) << ptr_d);
        done_d = (state_d == StDone);
        busy_d = (state_d != StIdle);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q <= StIdle;
            mask_q  <= '0;
            pend_q  <= '0;
            fire_q  <= '0;
            err_q   <= '0;
            ptr_q   <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            fire_q  <= fire_d;
            err_q   <= err_d;
            ptr_q   <= ptr_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
        end
    end

    assign fire_ch    = fire_q;
    assign done_pchip = done_q;
    assign busy       = busy_q;
    assign err_ch     = err_q;
    assign ovr        = ovr_q;

endmodule

// File: tb/tb_pchip_seq.sv
// Self-checking bench for pchip_seq: per-cycle vector table plus hand-written reset and
// timeout sequences (timeout part only when PCHIP_SEQ_TIMEOUT_EN is defined).
module tb_pchip_seq;

    logic        clk_sys = 1'b0;
    logic        rst = 1'b1;
    logic        fire_pchip = 1'b0;
    logic [3:0]  ch_en = '0;
    logic        mode_par = 1'b0;
    logic [15:0] to_lim = '0;
    logic        done_pchip;
    logic        busy;
    logic [3:0]  fire_ch;
    logic [3:0]  done_ch = '0;
    logic [3:0]  err_ch;
    logic        ovr;

    int n_chk = 0;
    int n_err = 0;

    pchip_seq #(
        .N_CH(4),
        .TO_W(16)
    ) dut (
        .clk_sys   (clk_sys),
        .rst       (rst),
        .fire_pchip(fire_pchip),
        .ch_en     (ch_en),
        .mode_par  (mode_par),
        .to_lim    (to_lim),
        .done_pchip(done_pchip),
        .busy      (busy),
        .fire_ch   (fire_ch),
        .done_ch   (done_ch),
        .err_ch    (err_ch),
        .ovr       (ovr)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic       fire;
        logic [3:0] en;
        logic       mode;
        logic [3:0] dc;
        logic [3:0] fc;
        logic       done;
        logic       busy;
        logic       ovr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic f, input logic [3:0] en, input logic m,
                               input logic [3:0] dc, input logic [3:0] fc, input logic d,
                               input logic b, input logic o);
        vec_t r;
        r.fire = f; r.en = en; r.mode = m; r.dc = dc;
        r.fc = fc; r.done = d; r.busy = b; r.ovr = o;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs hold for one cycle; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic f, input logic [3:0] en, input logic m, input logic [3:0] dc);
        fire_pchip = f;
        ch_en      = en;
        mode_par   = m;
        done_ch    = dc;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] fc, input logic d,
                              input logic b, input logic o, input logic [3:0] er);
        chk({tag, ".fire_ch"}, 32'(fire_ch), 32'(fc));
        chk({tag, ".done_pchip"}, 32'(done_pchip), 32'(d));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".ovr"}, 32'(ovr), 32'(o));
        chk({tag, ".err_ch"}, 32'(err_ch), 32'(er));
    endtask

    initial begin
        // Sequential, mask 1011, each done 3 cycles after its fire; mid-sequence fire sets ovr.
        tbl.push_back(v(1, 4'b1011, 0, 4'b0000, 4'b0001, 0, 1, 0));
        tbl.push_back(v(0, 4'b0000, 0, 4'b0001, 4'b0000, 0, 1, 0)); // done in FIRE ignored
        tbl.push_back(v(0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 1, 0));
        tbl.push_back(v(0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 1, 0));
        tbl.push_back(v(0, 4'b0000, 0, 4'b0001, 4'b0010, 0, 1, 0));
        tbl.push_back(v(0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 1, 0));
        tbl.push_back(v(0, 4'b0000, 0, 4'b1000, 4'b0000, 0, 1, 0)); // non-ptr done ignored
        tbl.push_back(v(0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 1, 0));
        tbl.push_back(v(0, 4'b0000, 0, 4'b0010, 4'b1000, 0, 1, 0));
        tbl.push_back(v(0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 1, 0));
        tbl.push_back(v(1, 4'b1111, 1, 4'b0000, 4'b0000, 0, 1, 1)); // fire while busy
        tbl.push_back(v(0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 1, 1));
        tbl.push_back(v(0, 4'b0000, 0, 4'b1000, 4'b0000, 1, 1, 1));
        tbl.push_back(v(0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 1));
        // Parallel, mask 0110, done[1] at +2 (and a duplicate), done[2] at +5.
        tbl.push_back(v(1, 4'b0110, 1, 4'b0000, 4'b0110, 0, 1, 0));
        tbl.push_back(v(0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 1, 0));
        tbl.push_back(v(0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 1, 0));
        tbl.push_back(v(0, 4'b0000, 0, 4'b0010, 4'b0000, 0, 1, 0));
        tbl.push_back(v(0, 4'b0000, 0, 4'b0010, 4'b0000, 0, 1, 0));
        tbl.push_back(v(0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 1, 0));
        tbl.push_back(v(0, 4'b0000, 0, 4'b0100, 4'b0000, 1, 1, 0));
        tbl.push_back(v(0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0));
        // Parallel, simultaneous dones; fire in the DONE cycle is dropped and sets ovr.
        tbl.push_back(v(1, 4'b0110, 1, 4'b0000, 4'b0110, 0, 1, 0));
        tbl.push_back(v(0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 1, 0));
        tbl.push_back(v(0, 4'b0000, 0, 4'b0110, 4'b0000, 1, 1, 0));
        tbl.push_back(v(1, 4'b0110, 1, 4'b0000, 4'b0000, 0, 0, 1));
        tbl.push_back(v(0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 1));
        // Empty mask: done one cycle after accept, no fire.
        tbl.push_back(v(1, 4'b0000, 0, 4'b0000, 4'b0000, 1, 1, 0));
        tbl.push_back(v(0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0));

        // Reset state.
        rst = 1'b1;
        step(0, 4'b0000, 0, 4'b0000);
        step(1, 4'b1111, 0, 4'b1111);
        expect_out("reset", 4'b0000, 0, 0, 0, 4'b0000);
        rst = 1'b0;
        step(0, 4'b0000, 0, 4'b0000);
        expect_out("idle", 4'b0000, 0, 0, 0, 4'b0000);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].fire, tbl[i].en, tbl[i].mode, tbl[i].dc);
            expect_out($sformatf("vec%0d", i), tbl[i].fc, tbl[i].done, tbl[i].busy, tbl[i].ovr,
                       4'b0000);
        end

        // Reset in WAIT aborts silently; a fresh request then runs cleanly.
        step(1, 4'b0001, 0, 4'b0000);
        expect_out("rst.fire", 4'b0001, 0, 1, 0, 4'b0000);
        step(1, 4'b0001, 0, 4'b0000);
        expect_out("rst.wait", 4'b0000, 0, 1, 1, 4'b0000);
        rst = 1'b1;
        step(0, 4'b0000, 0, 4'b0001);
        expect_out("rst.abort", 4'b0000, 0, 0, 0, 4'b0000);
        rst = 1'b0;
        step(1, 4'b0001, 0, 4'b0000);
        expect_out("rst.refire", 4'b0001, 0, 1, 0, 4'b0000);
        step(0, 4'b0000, 0, 4'b0000);
        expect_out("rst.rewait", 4'b0000, 0, 1, 0, 4'b0000);
        step(0, 4'b0000, 0, 4'b0001);
        expect_out("rst.done", 4'b0000, 1, 1, 0, 4'b0000);
        step(0, 4'b0000, 0, 4'b0000);
        expect_out("rst.idle", 4'b0000, 0, 0, 0, 4'b0000);

`ifdef PCHIP_SEQ_TIMEOUT_EN
        // Sequential 0011, limit 5, channel 1 silent (run 0) or done in the expiry cycle (run 1).
        to_lim = 16'd5;
        for (int r = 0; r < 2; r++) begin
            step(1, 4'b0011, 0, 4'b0000);
            expect_out($sformatf("to%0d.fire0", r), 4'b0001, 0, 1, 0, 4'b0000);
            step(0, 4'b0000, 0, 4'b0000);
            step(0, 4'b0000, 0, 4'b0001);
            expect_out($sformatf("to%0d.fire1", r), 4'b0010, 0, 1, 0, 4'b0000);
            step(0, 4'b0000, 0, 4'b0000);
            for (int k = 0; k < 4; k++) begin
                step(0, 4'b0000, 0, 4'b0000);
                expect_out($sformatf("to%0d.wait%0d", r, k), 4'b0000, 0, 1, 0, 4'b0000);
            end
            step(0, 4'b0000, 0, (r == 1) ? 4'b0010 : 4'b0000);
            expect_out($sformatf("to%0d.done", r), 4'b0000, 1, 1, 0,
                       (r == 1) ? 4'b0000 : 4'b0010);
            step(0, 4'b0000, 0, 4'b0000);
            expect_out($sformatf("to%0d.idle", r), 4'b0000, 0, 0, 0,
                       (r == 1) ? 4'b0000 : 4'b0010);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
